data_mem_access: RTL and testbench

Multi-cycle data-memory access unit for the MEM stage. It accepts load/store requests from the pipeline, performs byte-lane-masked writes for sw/sh/sb, and returns the raw aligned 32-bit word. It also returns the registered address-select bits that the downstream load-extend stage uses to pick the half or byte. It inserts a programmable number of wait states and stalls the pipeline while an access is outstanding.

---
 rtl/data_mem_access_pkg.sv | 29 ++
 rtl/data_mem_access_lane_mask.sv | 29 ++
 rtl/data_mem_access.sv | 145 ++++++++++++++
 tb/tb_data_mem_access.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_access_pkg.sv
// Shared encodings for the MEM-stage data memory access unit: access sizes,
// FSM states and the wait-state ceiling that sizes the wait counter.
package data_mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_BYTE     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ACCESS = 2'b10
  } state_e;

  localparam int unsigned WAIT_STATES_MAX = 15;

  // Words need a 4-byte boundary, halves a 2-byte one; bytes are always aligned.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: return addr_lo[0];
      SIZE_BYTE: return 1'b0;
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_access_lane_mask.sv
// Store lane decode: picks the byte lanes touched by a store and replicates
// the right-justified store data across the word so every lane sees it.
module dmem_lane_mask
  import data_mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  lane_en_o,
  output logic [31:0] wword_o
);

  always_comb begin
    lane_en_o = 4'b1111;
    wword_o   = wdata_i;
    case (size_i)
      SIZE_HALF: begin
        lane_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o   = {2{wdata_i[15:0]}};
      end
      SIZE_BYTE: begin
        lane_en_o = 4'b0001 << addr_lo_i;
        wword_o   = {4{wdata_i[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// Multi-cycle data memory access unit: latches a load/store in IDLE, waits
// WAIT_STATES cycles, commits in ACCESS and returns the raw aligned word.
module data_mem_access
  import data_mem_access_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        HalfSel,
  output logic [1:0]  ByteSel,
  output logic        ReadValid,
  output logic        Stall,
  output logic        Misaligned,
  output state_e      dbg_state_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(WAIT_STATES_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_INIT =
    CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, wr_q;
  logic [1:0]         size_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [1:0]         bsel_q;
  logic               valid_q, mis_q;
  logic               accept, reject;
  logic               req, req_mis;
  logic [3:0]         lane_en;
  logic [31:0]        wword;
  logic [ADDR_W-1:0]  widx;
  logic               commit_wr, commit_rd;
  logic               unused_addr_hi;

  logic [31:0] mem [DEPTH];

  assign req            = MemRead | MemWrite;
  assign req_mis        = is_misaligned(MemSize, Address[1:0]);
  assign widx           = addr_q[ADDR_W+1:2];
  assign commit_wr      = (state_q == ST_ACCESS) && wr_q;
  assign commit_rd      = (state_q == ST_ACCESS) && rd_q && !wr_q;
  assign unused_addr_hi = ^Address[31:ADDR_W+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    reject  = 1'b0;
    Stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (req_mis) begin
            reject = 1'b1;
          end else begin
            accept = 1'b1;
            Stall  = 1'b1;
            if (WAIT_STATES == 0) begin
              state_d = ST_ACCESS;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_INIT;
            end
          end
        end
      end
      ST_WAIT: begin
        Stall = 1'b1;
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bsel_q  <= 2'b00;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= commit_rd;
      mis_q   <= reject;
      if (accept) begin
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        size_q  <= MemSize;
        addr_q  <= Address[ADDR_W+1:0];
        wdata_q <= WriteData;
      end
      if (commit_rd) begin
        rdata_q <= mem[widx];
        bsel_q  <= addr_q[1:0];
      end
    end
  end

  dmem_lane_mask u_lane_mask (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .lane_en_o (lane_en),
    .wword_o   (wword)
  );

  // Storage is deliberately not reset; reset only drops the in-flight op.
  always_ff @(posedge Clk) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign ReadData    = rdata_q;
  assign HalfSel     = bsel_q[1];
  assign ByteSel     = bsel_q;
  assign ReadValid   = valid_q;
  assign Misaligned  = mis_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: two instances (one and zero wait states) driven
// with directed and random load/store traffic against a word-array model.
module tb_data_mem_access;
  import data_mem_access_pkg::*;

  localparam int DEPTH = 64;
  localparam int WS0   = 1;
  localparam int WS1   = 0;

  logic        clk;
  logic        rst_n       [2];
  logic        mem_read    [2];
  logic        mem_write   [2];
  logic [1:0]  mem_size    [2];
  logic [31:0] address     [2];
  logic [31:0] write_data  [2];
  logic [31:0] read_data   [2];
  logic        half_sel    [2];
  logic [1:0]  byte_sel    [2];
  logic        read_valid  [2];
  logic        stall       [2];
  logic        misaligned  [2];
  state_e      dbg_state   [2];

  // Reference model: plain word array plus the last completed load's outputs.
  logic [31:0] mem_m   [2][DEPTH];
  logic [31:0] rdata_m [2];
  logic [1:0]  bsel_m  [2];
  logic [31:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  data_mem_access #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
    .Clk(clk), .Rst_n(rst_n[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .MemSize(mem_size[0]), .Address(address[0]), .WriteData(write_data[0]),
    .ReadData(read_data[0]), .HalfSel(half_sel[0]), .ByteSel(byte_sel[0]),
    .ReadValid(read_valid[0]), .Stall(stall[0]), .Misaligned(misaligned[0]),
    .dbg_state_o(dbg_state[0])
  );

  data_mem_access #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .MemSize(mem_size[1]), .Address(address[1]), .WriteData(write_data[1]),
    .ReadData(read_data[1]), .HalfSel(half_sel[1]), .ByteSel(byte_sel[1]),
    .ReadValid(read_valid[1]), .Stall(stall[1]), .Misaligned(misaligned[1]),
    .dbg_state_o(dbg_state[1])
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs(input int k);
    mem_read[k]   = 1'b0;
    mem_write[k]  = 1'b0;
    mem_size[k]   = 2'b00;
    address[k]    = 32'h0;
    write_data[k] = 32'h0;
  endtask

  task automatic scramble(input int k);
    mem_read[k]   = 1'($urandom);
    mem_write[k]  = 1'($urandom);
    mem_size[k]   = 2'($urandom);
    address[k]    = $urandom;
    write_data[k] = $urandom;
  endtask

  task automatic check_reset_state(input int k);
    check("rst_rdata", read_data[k], 32'h0);
    check("rst_half", half_sel[k], 1'b0);
    check("rst_bsel", byte_sel[k], 2'b00);
    check("rst_rvalid", read_valid[k], 1'b0);
    check("rst_stall", stall[k], 1'b0);
    check("rst_mis", misaligned[k], 1'b0);
    check("rst_state", dbg_state[k], ST_IDLE);
  endtask

  // Entered at a negedge with the unit idle; returns at the negedge of the
  // cycle after completion (ReadValid cycle), so calls chain back-to-back.
  task automatic access(input int k, input bit rd, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    bit          mis;
    bit          is_load;
    int unsigned idx;
    int          sh;
    logic [31:0] word;
    logic [31:0] got;
    mis     = (sz == 2'b01) ? a[0] : (sz == 2'b10) ? 1'b0 : (a[1:0] != 2'b00);
    is_load = rd && !wr;
    idx     = (a >> 2) % DEPTH;
    mem_read[k]   = rd;
    mem_write[k]  = wr;
    mem_size[k]   = sz;
    address[k]    = a;
    write_data[k] = wd;
    #1;
    check("stall_req", stall[k], !mis);
    if (mis) begin
      @(negedge clk);
      check("mis_pulse", misaligned[k], 1'b1);
      check("mis_rvalid", read_valid[k], 1'b0);
      check("mis_rdata", read_data[k], rdata_m[k]);
      check("mis_bsel", byte_sel[k], bsel_m[k]);
      idle_inputs(k);
      return;
    end
    if (is_load) begin
      exp_q.push_back(mem_m[k][idx]);
    end else begin
      word = mem_m[k][idx];
      sh   = int'(a[1:0]);
      case (sz)
        2'b01:   if (a[1]) word[31:16] = wd[15:0]; else word[15:0] = wd[15:0];
        2'b10:   word[sh*8 +: 8] = wd[7:0];
        default: word = wd;
      endcase
      mem_m[k][idx] = word;
    end
    for (int c = 0; c < ws_of(k); c++) begin
      @(negedge clk);
      scramble(k);
      #1;
      check("stall_wait", stall[k], 1'b1);
      check("rvalid_wait", read_valid[k], 1'b0);
    end
    @(negedge clk);
    scramble(k);
    #1;
    check("stall_access", stall[k], 1'b0);
    check("mis_access", misaligned[k], 1'b0);
    @(negedge clk);
    check("rvalid", read_valid[k], is_load);
    check("mis_done", misaligned[k], 1'b0);
    if (is_load && exp_q.size() > 0) begin
      got         = exp_q.pop_front();
      rdata_m[k]  = got;
      bsel_m[k]   = a[1:0];
    end
    check("rdata", read_data[k], rdata_m[k]);
    check("bsel", byte_sel[k], bsel_m[k]);
    check("half", half_sel[k], bsel_m[k][1]);
    idle_inputs(k);
  endtask

  task automatic idle_cycle(input int k);
    idle_inputs(k);
    #1;
    check("idle_stall", stall[k], 1'b0);
    @(negedge clk);
    check("idle_rvalid", read_valid[k], 1'b0);
    check("idle_mis", misaligned[k], 1'b0);
  endtask

  task automatic random_ops(input int k, input int n);
    int          r;
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 3);
      rd = (r != 1);
      wr = (r == 1) || (r == 2);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, DEPTH * 16 - 1);
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'b01)      a[0]   = 1'b0;
        else if (sz != 2'b10) a[1:0] = 2'b00;
      end
      access(k, rd, wr, sz, a, $urandom);
      if ($urandom_range(0, 7) == 0) idle_cycle(k);
    end
  endtask

  // Main sequence
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k]   = 1'b0;
      rdata_m[k] = 32'h0;
      bsel_m[k]  = 2'b00;
      idle_inputs(k);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) check_reset_state(k);
    for (int k = 0; k < 2; k++) rst_n[k] = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) access(k, 1'b0, 1'b1, 2'b00, 32'(i * 4), $urandom);
    end

    // One-wait-state instance: directed sequence
    access(0, 1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    check("tp_sw_lw", read_data[0], 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 2'b01, 32'h12, 32'h00001234);
    access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    check("tp_sh_lw", read_data[0], 32'h1234BEEF);
    access(0, 1'b1, 1'b0, 2'b01, 32'h12, 32'h0);
    check("tp_lh_half", half_sel[0], 1'b1);
    access(0, 1'b0, 1'b1, 2'b10, 32'h11, 32'h000000AA);
    access(0, 1'b1, 1'b0, 2'b10, 32'h11, 32'h0);
    check("tp_sb_data", read_data[0], 32'h1234AAEF);
    check("tp_sb_bsel", byte_sel[0], 2'b01);
    access(0, 1'b1, 1'b0, 2'b00, 32'h13, 32'h0);
    check("tp_mis_hold", read_data[0], 32'h1234AAEF);
    idle_cycle(0);

    // Reset while a store is waiting: store dropped, memory kept
    mem_read[0]   = 1'b0;
    mem_write[0]  = 1'b1;
    mem_size[0]   = 2'b00;
    address[0]    = 32'h20;
    write_data[0] = 32'h00000055;
    #1;
    check("rst_req_stall", stall[0], 1'b1);
    @(negedge clk);
    check("rst_in_wait", dbg_state[0], ST_WAIT);
    rst_n[0] = 1'b0;
    idle_inputs(0);
    #1;
    rdata_m[0] = 32'h0;
    bsel_m[0]  = 2'b00;
    check_reset_state(0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    access(0, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
    check("rst_mem_kept", read_data[0], mem_m[0][8]);

    // Zero-wait-state instance: back-to-back loads and address wrap
    access(1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("ws0_lw0", read_data[1], mem_m[1][0]);
    access(1, 1'b1, 1'b0, 2'b00, 32'h4, 32'h0);
    check("ws0_lw4", read_data[1], mem_m[1][1]);
    access(1, 1'b1, 1'b0, 2'b00, 32'(DEPTH * 4), 32'h0);
    check("ws0_wrap", read_data[1], mem_m[1][0]);

    random_ops(0, 150);
    random_ops(1, 150);

    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
